tick_debouncer: RTL and testbench

Consumer of the periodic one-cycle tick strobe produced by the design's 10 ms tick generator. The block synchronizes WIDTH raw, bouncing push-button or switch inputs into the clock domain. It samples them only on tick cycles and accepts a new level only after STABLE_TICKS consecutive ticks agree. It outputs clean levels plus one-cycle press and release pulses for downstream control logic.

---
 rtl/tick_debouncer.sv | 52 +++++
 tb/tb_tick_debouncer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_debouncer.sv
// tick_debouncer: synchronizes raw buttons and accepts a new level after STABLE_TICKS agreeing tick samples
module tick_debouncer #(
    parameter int WIDTH        = 4,
    parameter int STABLE_TICKS = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             tick_in,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);
    logic [WIDTH-1:0] meta_q, sync_q, level_q, level_d, press_q, press_d, release_q, release_d, accept;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    // a differing tick sample advances the count; a bounce or acceptance restarts it
    always_comb begin
        accept = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = tick_in && (sync_q[i] != level_q[i]) && (cnt_q[i] == LAST);
            cnt_d[i]  = !tick_in ? cnt_q[i] : (sync_q[i] == level_q[i] || accept[i]) ? '0 : cnt_q[i] + 1'b1;
        end
        level_d   = level_q ^ accept;
        press_d   = accept & sync_q;
        release_d = accept & ~sync_q;
    end
    // two-flop synchronizer, accepted levels, counters and registered pulses
    always_ff @(posedge clock_in) begin
        if (reset) begin
            meta_q    <= '0;
            sync_q    <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            meta_q    <= btn_in;
            sync_q    <= meta_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end
    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
endmodule

// File: tb/tb_tick_debouncer.sv
// tb_tick_debouncer: scoreboard plus directed scenario checks for tick_debouncer
module tb_tick_debouncer;
    logic clk = 0, rst = 1, tick = 0, tick1 = 1;
    logic [3:0] btn = '0, btn1 = '0;
    logic [3:0] lvl, prs, rel, lvl1, prs1, rel1;
    int checks = 0, fails = 0, tcnt = 0, ntick = 0;
    int pc [4] = '{default: 0};
    int rc [4] = '{default: 0};
    int ptick [4] = '{default: 0};
    int rtick [4] = '{default: 0};
    logic [3:0] pvec = '0;
    logic [11:0] qa [$];
    logic [11:0] qb [$];
    logic [3:0] ma_s1, ma_s2, ma_lvl, mb_s1, mb_s2, mb_lvl;
    logic [3:0][7:0] ma_run, mb_run;

    always #5 clk = ~clk;

    tick_debouncer dut_a (
        .clock_in(clk), .reset(rst), .tick_in(tick), .btn_in(btn),
        .btn_level(lvl), .btn_press(prs), .btn_release(rel)
    );
    tick_debouncer #(.WIDTH(4), .STABLE_TICKS(1), .CNT_W(3)) dut_b (
        .clock_in(clk), .reset(rst), .tick_in(tick1), .btn_in(btn1),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1)
    );

    // one tick every 10 cycles, changed away from the sampling edge
    always @(negedge clk) begin
        tick <= (tcnt == 9);
        tcnt <= (tcnt == 9) ? 0 : tcnt + 1;
    end

    always @(posedge clk) if (tick && !rst) ntick <= ntick + 1;

    // pulse bookkeeping for dut_a used by the directed scenarios
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (prs[i]) begin pc[i] <= pc[i] + 1; ptick[i] <= ntick; end
            if (rel[i]) begin rc[i] <= rc[i] + 1; rtick[i] <= ntick; end
        end
        if (prs != 4'b0) pvec <= prs;
    end

    task automatic model_step(input int st, input logic r, input logic t, input logic [3:0] s2,
                              input logic [3:0] lv, input logic [3:0][7:0] run,
                              output logic [3:0] nl, output logic [3:0] pr, output logic [3:0] rl,
                              output logic [3:0][7:0] nr);
        nl = r ? 4'b0 : lv;
        pr = '0;
        rl = '0;
        nr = '0;
        if (!r) for (int i = 0; i < 4; i++) begin
            nr[i] = run[i];
            if (t) begin
                if (s2[i] == lv[i]) nr[i] = 8'd0;
                else if (int'(run[i]) + 1 >= st) begin
                    nl[i] = s2[i]; pr[i] = s2[i]; rl[i] = ~s2[i]; nr[i] = 8'd0;
                end else nr[i] = run[i] + 8'd1;
            end
        end
    endtask

    always @(posedge clk) begin : model_a
        logic [3:0] nl, pr, rl;
        logic [3:0][7:0] nr;
        model_step(4, rst, tick, ma_s2, ma_lvl, ma_run, nl, pr, rl, nr);
        ma_s1 <= rst ? 4'b0 : btn;
        ma_s2 <= rst ? 4'b0 : ma_s1;
        ma_lvl <= nl;
        ma_run <= nr;
        qa.push_back({nl, pr, rl});
    end

    always @(posedge clk) begin : model_b
        logic [3:0] nl, pr, rl;
        logic [3:0][7:0] nr;
        model_step(1, rst, tick1, mb_s2, mb_lvl, mb_run, nl, pr, rl, nr);
        mb_s1 <= rst ? 4'b0 : btn1;
        mb_s2 <= rst ? 4'b0 : mb_s1;
        mb_lvl <= nl;
        mb_run <= nr;
        qb.push_back({nl, pr, rl});
    end

    always @(negedge clk) begin : sb_check
        logic [11:0] e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            checks++;
            if ({lvl, prs, rel} !== e) begin
                fails++;
                $display("FAIL sb_a at %0t: level/press/release got %b/%b/%b want %b/%b/%b", $time, lvl, prs, rel, e[11:8], e[7:4], e[3:0]);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            checks++;
            if ({lvl1, prs1, rel1} !== e) begin
                fails++;
                $display("FAIL sb_b at %0t: level/press/release got %b/%b/%b want %b/%b/%b", $time, lvl1, prs1, rel1, e[11:8], e[7:4], e[3:0]);
            end
        end
    end

    task automatic align();
        int n = 0;
        do begin @(negedge clk); n++; end while (!tick && n < 40);
        if (!tick) begin checks++; fails++; $display("FAIL align: no tick within %0d cycles", n); end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({lvl, prs, rel} !== 12'h0) begin fails++; $display("FAIL reset_a: got %h want 000", {lvl, prs, rel}); end
        checks++;
        if ({lvl1, prs1, rel1} !== 12'h0) begin fails++; $display("FAIL reset_b: got %h want 000", {lvl1, prs1, rel1}); end
        rst = 0;
    endtask

    task automatic test_clean_press();
        int b;
        int p0 [4];
        int r0 [4];
        align();
        p0 = pc; r0 = rc; b = ntick;
        btn[0] = 1'b1;
        repeat (3) align();
        checks++;
        if (lvl[0] !== 1'b0) begin fails++; $display("FAIL press_early: level0 got %b want 0", lvl[0]); end
        repeat (2) align();
        checks++;
        if (lvl !== 4'b0001) begin fails++; $display("FAIL press_level: got %b want 0001", lvl); end
        checks++;
        if (pc[0] - p0[0] != 1) begin fails++; $display("FAIL press_count: got %0d want 1", pc[0] - p0[0]); end
        checks++;
        if (ptick[0] - b != 4) begin fails++; $display("FAIL press_tick: got %0d want 4", ptick[0] - b); end
        checks++;
        if (pc[1] - p0[1] + pc[2] - p0[2] + pc[3] - p0[3] + rc[0] - r0[0] + rc[1] - r0[1] + rc[2] - r0[2] + rc[3] - r0[3] != 0) begin
            fails++; $display("FAIL press_others: got nonzero extra pulses want 0");
        end
    endtask

    task automatic test_bounce();
        int b;
        int p0 [4];
        align();
        p0 = pc; b = ntick;
        btn[1] = 1'b1;
        repeat (3) align();
        btn[1] = 1'b0;
        align();
        btn[1] = 1'b1;
        repeat (3) align();
        checks++;
        if (lvl[1] !== 1'b0) begin fails++; $display("FAIL bounce_early: level1 got %b want 0", lvl[1]); end
        repeat (2) align();
        checks++;
        if (lvl[1] !== 1'b1) begin fails++; $display("FAIL bounce_level: level1 got %b want 1", lvl[1]); end
        checks++;
        if (pc[1] - p0[1] != 1) begin fails++; $display("FAIL bounce_count: got %0d want 1", pc[1] - p0[1]); end
        checks++;
        if (ptick[1] - b != 8) begin fails++; $display("FAIL bounce_tick: got %0d want 8", ptick[1] - b); end
    endtask

    task automatic test_release();
        int b;
        int p0 [4];
        int r0 [4];
        align();
        p0 = pc; r0 = rc; b = ntick;
        btn[0] = 1'b0;
        repeat (3) align();
        checks++;
        if (lvl[0] !== 1'b1) begin fails++; $display("FAIL release_early: level0 got %b want 1", lvl[0]); end
        repeat (2) align();
        checks++;
        if (lvl[0] !== 1'b0) begin fails++; $display("FAIL release_level: level0 got %b want 0", lvl[0]); end
        checks++;
        if (rc[0] - r0[0] != 1) begin fails++; $display("FAIL release_count: got %0d want 1", rc[0] - r0[0]); end
        checks++;
        if (pc[0] - p0[0] != 0) begin fails++; $display("FAIL release_press: got %0d want 0", pc[0] - p0[0]); end
        checks++;
        if (rtick[0] - b != 4) begin fails++; $display("FAIL release_tick: got %0d want 4", rtick[0] - b); end
    endtask

    task automatic test_simultaneous();
        int b;
        int p0 [4];
        btn = 4'b0000;
        repeat (6) align();
        p0 = pc; b = ntick;
        btn = 4'b1010;
        repeat (5) align();
        checks++;
        if (lvl !== 4'b1010) begin fails++; $display("FAIL simul_level: got %b want 1010", lvl); end
        checks++;
        if (pvec !== 4'b1010) begin fails++; $display("FAIL simul_vec: got %b want 1010", pvec); end
        checks++;
        if (pc[1] - p0[1] != 1 || pc[3] - p0[3] != 1) begin
            fails++; $display("FAIL simul_count: got %0d/%0d want 1/1", pc[1] - p0[1], pc[3] - p0[3]);
        end
        checks++;
        if (ptick[1] - b != 4 || ptick[3] - b != 4) begin
            fails++; $display("FAIL simul_tick: got %0d/%0d want 4/4", ptick[1] - b, ptick[3] - b);
        end
    endtask

    task automatic test_reset_mid();
        int b;
        int p0 [4];
        btn = 4'b0000;
        repeat (6) align();
        align();
        btn[0] = 1'b1;
        repeat (2) align();
        rst = 1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if ({lvl, prs, rel} !== 12'h0) begin fails++; $display("FAIL rstmid_outputs: got %h want 000", {lvl, prs, rel}); end
        end
        rst = 0;
        p0 = pc; b = ntick;
        repeat (3) align();
        checks++;
        if (lvl[0] !== 1'b0) begin fails++; $display("FAIL rstmid_early: level0 got %b want 0", lvl[0]); end
        repeat (2) align();
        checks++;
        if (lvl[0] !== 1'b1) begin fails++; $display("FAIL rstmid_level: level0 got %b want 1", lvl[0]); end
        checks++;
        if (pc[0] - p0[0] != 1) begin fails++; $display("FAIL rstmid_count: got %0d want 1", pc[0] - p0[0]); end
        checks++;
        if (ptick[0] - b != 4) begin fails++; $display("FAIL rstmid_tick: got %0d want 4", ptick[0] - b); end
    endtask

    task automatic test_continuous();
        logic nv;
        @(negedge clk);
        for (int t = 0; t < 6; t++) begin
            btn1[2] = ~btn1[2];
            nv = btn1[2];
            for (int j = 1; j <= 5; j++) begin
                @(negedge clk);
                checks++;
                if (lvl1[2] !== (j >= 3 ? nv : ~nv)) begin fails++; $display("FAIL cont_level t%0d j%0d: got %b want %b", t, j, lvl1[2], (j >= 3 ? nv : ~nv)); end
                checks++;
                if (prs1[2] !== (j == 3 && nv)) begin fails++; $display("FAIL cont_press t%0d j%0d: got %b want %b", t, j, prs1[2], (j == 3 && nv)); end
                checks++;
                if (rel1[2] !== (j == 3 && !nv)) begin fails++; $display("FAIL cont_release t%0d j%0d: got %b want %b", t, j, rel1[2], (j == 3 && !nv)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
        test_continuous();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
